// File: rtl/iob_ram_sp_rd_stream.sv
// rtl/iob_ram_sp_rd_stream.sv - streams a block of consecutive single-port RAM words over valid/ready
// Optional read-and-clear mode: define RAM_RD_STREAM_CLEAR_EN (each read followed by a zero write).
module iob_ram_sp_rd_stream #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [LEN_W-1:0]  rd_cnt, rd_cnt_nxt;
  logic [LEN_W-1:0]  pop_cnt, pop_cnt_nxt;
  logic              in_flight;
  logic              zero_done;
  logic              issue;
  logic              done_xfer;
  logic              wr_phase, wr_phase_nxt;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic [1:0]        total;
  logic              pop, fifo_push, fifo_pop, room, last_rd, last_pop;

  // The word in flight counts as already queued: it is presented straight from
  // ram_dout and only written into the FIFO if the sink does not take it.
  assign m_valid   = (occ != 2'd0) | in_flight;
  assign m_data    = (occ != 2'd0) ? fifo_mem[rd_ptr] : (in_flight ? ram_dout : '0);
  assign pop       = m_valid & m_ready;
  assign fifo_pop  = pop & (occ != 2'd0);
  assign fifo_push = in_flight & ~(pop & (occ == 2'd0));
  assign total     = occ + {1'b0, in_flight};
  assign room      = (total < 2'd2) | pop;
  assign last_rd   = (rd_cnt == len_q - 1'b1);
  assign last_pop  = (pop_cnt == len_q - 1'b1);

  assign busy    = (state != IDLE);
  assign done    = zero_done | done_xfer;
  assign ram_din = '0;

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    len_nxt      = len_q;
    rd_cnt_nxt   = rd_cnt;
    pop_cnt_nxt  = pop_cnt;
    wr_phase_nxt = wr_phase;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    issue        = 1'b0;
    done_xfer    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          state_nxt    = READ;
          addr_nxt     = start_addr;
          len_nxt      = len;
          rd_cnt_nxt   = '0;
          pop_cnt_nxt  = '0;
          wr_phase_nxt = 1'b0;
        end
      end
      READ: begin
`ifdef RAM_RD_STREAM_CLEAR_EN
        if (wr_phase) begin
          ram_en       = 1'b1;
          ram_we       = 1'b1;
          ram_addr     = addr_q;
          addr_nxt     = addr_q + 1'b1;
          wr_phase_nxt = 1'b0;
          if (rd_cnt == len_q) state_nxt = DRAIN;
        end else if (room) begin
          ram_en       = 1'b1;
          ram_addr     = addr_q;
          issue        = 1'b1;
          rd_cnt_nxt   = rd_cnt + 1'b1;
          wr_phase_nxt = 1'b1;
        end
`else
        if (room) begin
          ram_en     = 1'b1;
          ram_addr   = addr_q;
          issue      = 1'b1;
          addr_nxt   = addr_q + 1'b1;
          rd_cnt_nxt = rd_cnt + 1'b1;
          if (last_rd) state_nxt = DRAIN;
        end
`endif
      end
      DRAIN: ;
      default: state_nxt = IDLE;
    endcase
    // In clear mode the final word can leave during its own write cycle, so the
    // completion check overrides whatever READ decided.
    if ((state != IDLE) && pop) begin
      pop_cnt_nxt = pop_cnt + 1'b1;
      if (last_pop) begin
        done_xfer = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      rd_cnt    <= '0;
      pop_cnt   <= '0;
      wr_phase  <= 1'b0;
      in_flight <= 1'b0;
      zero_done <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      len_q     <= len_nxt;
      rd_cnt    <= rd_cnt_nxt;
      pop_cnt   <= pop_cnt_nxt;
      wr_phase  <= wr_phase_nxt;
      in_flight <= issue;
      zero_done <= (state == IDLE) && start && (len == '0);
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_iob_ram_sp_rd_stream.sv
// tb/tb_iob_ram_sp_rd_stream.sv - directed vector bench for iob_ram_sp_rd_stream with a behavioural RAM
module tb_iob_ram_sp_rd_stream;

  logic       clk, rst, start, busy, done, ram_en, ram_we, m_valid, m_ready;
  logic [3:0] start_addr, ram_addr;
  logic [4:0] len;
  logic [7:0] ram_din, ram_dout, m_data;
  logic [7:0] mem [16];
  logic       reload;
  int         checks, errors;

  typedef struct {
    logic [3:0]  addr;
    logic [4:0]  len;
    logic [7:0]  rdy;
    int          poke;
    bit          timing;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [6];
  vec_t rvec;

  iob_ram_sp_rd_stream #(.DATA_W(8), .ADDR_W(4), .LEN_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " ram_en"}, ram_en, 0);
    chk({tag, " ram_we"}, ram_we, 0);
    chk({tag, " ram_addr"}, ram_addr, 0);
    chk({tag, " ram_din"}, ram_din, 0);
    chk({tag, " m_valid"}, m_valid, 0);
    chk({tag, " m_data"}, m_data, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int nrd, npop, first_v, done_cyc, pop_now;
    logic prev_hold, prev_rd;
    logic [7:0] prev_data;
    logic [3:0] exp_addr;
    bit got_done;
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    start = 1'b1; start_addr = v.addr; len = v.len; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    nrd = 0; npop = 0; first_v = -1; done_cyc = -1;
    prev_hold = 1'b0; prev_rd = 1'b0; prev_data = '0; got_done = 1'b0;
    for (int c = 0; c < 64 && !got_done; c++) begin
      m_ready = v.rdy[c % 8];
      if (c == v.poke) begin start = 1'b1; start_addr = 4'd9; len = 5'd1; end
      else start = 1'b0;
      #1;
      chk("busy during transfer", busy, 1);
      if (c == 0) chk("first ram_en latency", ram_en, 1);
      if (prev_hold) chk("m_data hold while stalled", m_data, prev_data);
      pop_now = (m_valid && m_ready) ? 1 : 0;
      if (ram_en && !ram_we) begin
        exp_addr = v.addr + 4'(nrd);
        chk("read address", ram_addr, exp_addr);
        chk("issue rule", (nrd - npop - pop_now) < 2, 1);
`ifdef RAM_RD_STREAM_CLEAR_EN
        chk("read follows write", prev_rd, 0);
`endif
        nrd++;
      end
`ifdef RAM_RD_STREAM_CLEAR_EN
      if (ram_en && ram_we) begin
        exp_addr = v.addr + 4'(nrd - 1);
        chk("write follows read", prev_rd, 1);
        chk("clear address", ram_addr, exp_addr);
        chk("clear data", ram_din, 0);
      end
`else
      chk("ram_we tied low", ram_we, 0);
`endif
      if (m_valid && first_v < 0) first_v = c;
      if (pop_now != 0) begin
        chk("stream word", m_data, v.exp[8*npop +: 8]);
        npop++;
        chk("done on handshake", done, npop == v.len);
        if (done) begin got_done = 1'b1; done_cyc = c; end
      end else begin
        chk("no done without handshake", done, 0);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_rd   = ram_en && !ram_we;
      @(negedge clk);
    end
    start = 1'b0;
    chk("transfer completed within budget", got_done, 1);
    chk("read count", nrd, v.len);
    if (v.timing) begin
      chk("first m_valid latency", first_v, 1);
`ifdef RAM_RD_STREAM_CLEAR_EN
      chk("done cycle", done_cyc, 2 * v.len - 1);
`else
      chk("done cycle", done_cyc, v.len);
`endif
    end
    #1;
    chk("busy after done", busy, 0);
    chk("done single pulse", done, 0);
    chk("m_valid after done", m_valid, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0; reload = 1'b1;
    vecs[0] = '{addr: 4'd4,  len: 5'd5, rdy: 8'hFF, poke: -1, timing: 1'b1,
                exp: {8'h00, 8'h18, 8'h17, 8'h16, 8'h15, 8'h14}};
    vecs[1] = '{addr: 4'd4,  len: 5'd5, rdy: 8'h55, poke: -1, timing: 1'b0,
                exp: {8'h00, 8'h18, 8'h17, 8'h16, 8'h15, 8'h14}};
    vecs[2] = '{addr: 4'd14, len: 5'd4, rdy: 8'hFF, poke: -1, timing: 1'b0,
                exp: {16'h0000, 8'h11, 8'h10, 8'h1F, 8'h1E}};
    vecs[3] = '{addr: 4'd2,  len: 5'd3, rdy: 8'hFF, poke: 1, timing: 1'b0,
                exp: {24'h000000, 8'h14, 8'h13, 8'h12}};
    vecs[4] = '{addr: 4'd0,  len: 5'd6, rdy: 8'h33, poke: -1, timing: 1'b0,
                exp: {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[5] = '{addr: 4'd15, len: 5'd1, rdy: 8'hFE, poke: -1, timing: 1'b0,
                exp: {40'h0, 8'h1F}};
    rvec    = '{addr: 4'd7,  len: 5'd6, rdy: 8'hFF, poke: -1, timing: 1'b0,
                exp: {8'h1C, 8'h1B, 8'h1A, 8'h19, 8'h18, 8'h17}};
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0; reload = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // zero-length request
    @(negedge clk);
    start = 1'b1; start_addr = 4'd5; len = 5'd0; m_ready = 1'b1;
    #1;
    chk("len0 no busy at start", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("len0 done", done, 1);
    chk("len0 busy", busy, 0);
    chk("len0 ram_en", ram_en, 0);
    chk("len0 m_valid", m_valid, 0);
    @(negedge clk);
    #1;
    chk("len0 done pulse width", done, 0);
    chk("len0 busy later", busy, 0);

    // asynchronous reset part-way through a transfer
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    start = 1'b1; start_addr = 4'd3; len = 5'd6; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("busy before reset", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    run_vec(rvec);

`ifdef RAM_RD_STREAM_CLEAR_EN
    begin
      vec_t cv;
      cv = '{addr: 4'd0, len: 5'd3, rdy: 8'hFF, poke: -1, timing: 1'b1,
             exp: {24'h000000, 8'h12, 8'h11, 8'h10}};
      run_vec(cv);
      chk("cleared mem0", mem[0], 8'h00);
      chk("cleared mem1", mem[1], 8'h00);
      chk("cleared mem2", mem[2], 8'h00);
      chk("untouched mem3", mem[3], 8'h13);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
